complex_mag_stream_mul_pipe_ext: RTL and testbench



---
 rtl/complex_mag_stream_mul_pipe_ext.sv | 136 +++++++++++++
 tb/tb_complex_mag_stream_mul_pipe_ext.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mag_stream_mul_pipe_ext.sv
// Pipelined integer multiplier with per-operand signedness, a configurable
// depth, right-shift scaling with optional round-half-up, optional saturation
// with an overflow flag, and a valid sideband that follows the data.
module complex_mag_stream_mul_pipe_ext #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 5,
    parameter int din0_WIDTH = 44,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 50,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  ovf
);

    // Full product width, and the number of product registers from stage 2
    // up to stage NUM_STAGE-1.
    localparam int P   = din0_WIDTH + din1_WIDTH;
    localparam int DLY = NUM_STAGE - 2;

    // Comparison width: wide enough for the rounded product and for both
    // output range limits, so every fit test is an exact signed compare.
    localparam int CW = (P > dout_WIDTH) ? P + 2 : dout_WIDTH + 2;

    localparam bit PROD_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
    localparam bit EXT0        = (SIGNED0 != 0);
    localparam bit EXT1        = (SIGNED1 != 0);

    // Rounding constant 2^(SHIFT-1); shifting one up and back down yields 0
    // naturally when SHIFT is 0.
    localparam logic [P+1:0] ONE_P     = {{(P+1){1'b0}}, 1'b1};
    localparam logic [P+1:0] ROUND_ADD = (ROUND != 0) ? ((ONE_P << SHIFT) >> 1) : '0;

    // Output range limits expressed in the comparison width.
    localparam logic signed [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [CW-1:0] HI_LIM = PROD_SIGNED
                                              ? ((ONE_C <<< (dout_WIDTH-1)) - ONE_C)
                                              : ((ONE_C <<< dout_WIDTH) - ONE_C);
    localparam logic signed [CW-1:0] LO_LIM = PROD_SIGNED
                                              ? -(ONE_C <<< (dout_WIDTH-1))
                                              : {CW{1'b0}};

    // The instance tag only distinguishes instances; it drives no logic.
    if (ID < 0) begin : g_instanceTag
    end

    logic [din0_WIDTH-1:0] din0_q;
    logic [din1_WIDTH-1:0] din1_q;
    logic                  valid1_q;
    logic [P-1:0]          prod_q [DLY];
    logic [DLY-1:0]        validPipe_q;
    logic [dout_WIDTH-1:0] dout_q;
    logic                  ovf_q;
    logic                  doutValid_q;

    logic [P-1:0]          op0Ext;
    logic [P-1:0]          op1Ext;
    logic [P-1:0]          product_d;
    logic [P-1:0]          prodLast;
    logic signed [P+1:0]   sumA;
    logic signed [P+1:0]   shifted;
    logic signed [CW-1:0]  sWide;
    logic [dout_WIDTH-1:0] dout_d;
    logic                  ovf_d;

    // Extend both operands to the product width and multiply; the low P bits
    // of the product are exact for any signedness mix.
    always_comb begin
        op0Ext    = {{din1_WIDTH{EXT0 & din0_q[din0_WIDTH-1]}}, din0_q};
        op1Ext    = {{din0_WIDTH{EXT1 & din1_q[din1_WIDTH-1]}}, din1_q};
        product_d = op0Ext * op1Ext;
    end

    // Round, shift, test the fit against the output range, then either clamp
    // or wrap to form the final-stage result.
    always_comb begin
        prodLast = prod_q[DLY-1];
        sumA     = $signed({{2{PROD_SIGNED & prodLast[P-1]}}, prodLast} + ROUND_ADD);
        shifted  = sumA >>> SHIFT;
        sWide    = CW'(shifted);
        ovf_d    = (sWide > HI_LIM) || (sWide < LO_LIM);
        dout_d   = sWide[dout_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (sWide > HI_LIM) begin
                dout_d = HI_LIM[dout_WIDTH-1:0];
            end else if (sWide < LO_LIM) begin
                dout_d = LO_LIM[dout_WIDTH-1:0];
            end
        end
    end

    // All pipeline registers: reset clears everything, ce advances every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            din0_q      <= '0;
            din1_q      <= '0;
            valid1_q    <= 1'b0;
            for (int k = 0; k < DLY; k++) begin
                prod_q[k] <= '0;
            end
            validPipe_q <= '0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            doutValid_q <= 1'b0;
        end else if (ce) begin
            din0_q         <= din0;
            din1_q         <= din1;
            valid1_q       <= din_valid;
            prod_q[0]      <= product_d;
            validPipe_q[0] <= valid1_q;
            for (int k = 1; k < DLY; k++) begin
                prod_q[k]      <= prod_q[k-1];
                validPipe_q[k] <= validPipe_q[k-1];
            end
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            doutValid_q <= validPipe_q[DLY-1];
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_complex_mag_stream_mul_pipe_ext.sv
// Directed bench: one default-configured multiplier plus two signed 8x8->8
// instances (saturating and wrapping) sharing clock, reset and ce.
module tb_complex_mag_stream_mul_pipe_ext;

    logic        clk;
    logic        reset;
    logic        ce;

    logic [43:0] uDin0;
    logic [5:0]  uDin1;
    logic        uValid;
    logic [49:0] uDout;
    logic        uDoutValid;
    logic        uOvf;

    logic [7:0]  sDin0;
    logic [7:0]  sDin1;
    logic        sValid;
    logic [7:0]  satDout;
    logic        satValid;
    logic        satOvf;
    logic [7:0]  noDout;
    logic        noValid;
    logic        noOvf;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] satDout;
        logic       satOvf;
        logic [7:0] noDout;
        logic       noOvf;
    } vec_t;

    localparam int NV = 12;
    localparam int SLAT = 4;
    vec_t vecs [NV];

    complex_mag_stream_mul_pipe_ext dutDefault (
        .clk(clk), .reset(reset), .ce(ce),
        .din0(uDin0), .din1(uDin1), .din_valid(uValid),
        .dout(uDout), .dout_valid(uDoutValid), .ovf(uOvf)
    );

    complex_mag_stream_mul_pipe_ext #(
        .ID(2), .NUM_STAGE(SLAT), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
        .SIGNED0(1), .SIGNED1(1), .SHIFT(4), .ROUND(1), .SATURATE(1)
    ) dutSat (
        .clk(clk), .reset(reset), .ce(ce),
        .din0(sDin0), .din1(sDin1), .din_valid(sValid),
        .dout(satDout), .dout_valid(satValid), .ovf(satOvf)
    );

    complex_mag_stream_mul_pipe_ext #(
        .ID(3), .NUM_STAGE(SLAT), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
        .SIGNED0(1), .SIGNED1(1), .SHIFT(4), .ROUND(1), .SATURATE(0)
    ) dutWrap (
        .clk(clk), .reset(reset), .ce(ce),
        .din0(sDin0), .din1(sDin1), .din_valid(sValid),
        .dout(noDout), .dout_valid(noValid), .ovf(noOvf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [43:0] a, input logic [5:0] b, input logic v);
        uDin0  = a;
        uDin1  = b;
        uValid = v;
    endtask

    task automatic applySignedStimulus(input logic [7:0] a, input logic [7:0] b, input logic v);
        sDin0  = a;
        sDin1  = b;
        sValid = v;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Streams din0=1..8 with din1=3; idle cycles carry 5*7 with valid low so
    // dout is a known 35 whenever no result is valid. An optional stall of
    // stallLen ce=0 cycles starts at edge 3, before any result emerges.
    task automatic runStream(input int stallLen);
        int idx;
        int k;
        ce = 1'b1;
        applyStimulus(44'd5, 6'd7, 1'b0);
        repeat (6) tick();
        idx = 0;
        for (int e = 1; e <= 20; e++) begin
            ce = !(stallLen > 0 && e >= 3 && e < 3 + stallLen);
            if (idx < 8) begin
                applyStimulus(44'(idx + 1), 6'd3, 1'b1);
            end else begin
                applyStimulus(44'd5, 6'd7, 1'b0);
            end
            tick();
            if (ce) begin
                idx++;
            end
            k = e - (5 + stallLen);
            if (k >= 0 && k < 8) begin
                checkOutput($sformatf("stream%0d_e%0d_valid", stallLen, e), 64'(uDoutValid), 64'd1);
                checkOutput($sformatf("stream%0d_e%0d_dout", stallLen, e), 64'(uDout), 64'(3 * (k + 1)));
            end else begin
                checkOutput($sformatf("stream%0d_e%0d_valid", stallLen, e), 64'(uDoutValid), 64'd0);
                checkOutput($sformatf("stream%0d_e%0d_dout", stallLen, e), 64'(uDout), 64'd35);
            end
            checkOutput($sformatf("stream%0d_e%0d_ovf", stallLen, e), 64'(uOvf), 64'd0);
        end
        ce = 1'b1;
    endtask

    initial begin
        logic [63:0] bigExp;
        int j;

        checks   = 0;
        failures = 0;

        // Signed 8x8 vectors: {a, b, saturated dout, ovf, wrapped dout, ovf}.
        vecs[0]  = '{8'h07, 8'h09, 8'h04, 1'b0, 8'h04, 1'b0};
        vecs[1]  = '{8'h80, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
        vecs[2]  = '{8'h80, 8'h7F, 8'h80, 1'b1, 8'h08, 1'b1};
        vecs[3]  = '{8'hFD, 8'h05, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[4]  = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 8'hF0, 1'b1};
        vecs[5]  = '{8'h7F, 8'h10, 8'h7F, 1'b0, 8'h7F, 1'b0};
        vecs[6]  = '{8'h78, 8'h11, 8'h7F, 1'b1, 8'h80, 1'b1};
        vecs[7]  = '{8'h80, 8'h10, 8'h80, 1'b0, 8'h80, 1'b0};
        vecs[8]  = '{8'h87, 8'h11, 8'h80, 1'b1, 8'h7F, 1'b1};
        vecs[9]  = '{8'hFF, 8'h09, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[10] = '{8'h01, 8'h08, 8'h01, 1'b0, 8'h01, 1'b0};
        vecs[11] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        reset = 1'b1;
        ce    = 1'b1;
        applyStimulus(44'h0ABC, 6'd9, 1'b1);
        applySignedStimulus(8'h33, 8'h44, 1'b1);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_u_dout", 64'(uDout), 64'd0);
        checkOutput("rst_u_valid", 64'(uDoutValid), 64'd0);
        checkOutput("rst_u_ovf", 64'(uOvf), 64'd0);
        checkOutput("rst_sat_dout", 64'(satDout), 64'd0);
        checkOutput("rst_sat_valid", 64'(satValid), 64'd0);
        checkOutput("rst_wrap_ovf", 64'(noOvf), 64'd0);
        reset = 1'b0;
        applyStimulus(44'd0, 6'd0, 1'b0);
        applySignedStimulus(8'd0, 8'd0, 1'b0);
        repeat (6) tick();

        $display("[TB] single maximum operation");
        bigExp = ((64'd1 << 44) - 64'd1) * 64'd63;
        applyStimulus(44'hFFF_FFFF_FFFF, 6'd63, 1'b1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            applyStimulus(44'd0, 6'd0, 1'b0);
            if (e == 5) begin
                checkOutput("max_valid", 64'(uDoutValid), 64'd1);
                checkOutput("max_dout", 64'(uDout), bigExp);
                checkOutput("max_ovf", 64'(uOvf), 64'd0);
            end else begin
                checkOutput($sformatf("max_e%0d_valid", e), 64'(uDoutValid), 64'd0);
            end
        end

        $display("[TB] back-to-back stream");
        runStream(0);
        $display("[TB] stream with 3-cycle ce stall");
        runStream(3);

        $display("[TB] reset with operations in flight");
        applyStimulus(44'd5, 6'd7, 1'b0);
        repeat (6) tick();
        for (int e = 1; e <= 3; e++) begin
            applyStimulus(44'(e * 11), 6'd2, 1'b1);
            tick();
        end
        applyStimulus(44'd5, 6'd7, 1'b0);
        reset = 1'b1;
        ce    = 1'b0;
        tick();
        reset = 1'b0;
        ce    = 1'b1;
        checkOutput("midrst_dout", 64'(uDout), 64'd0);
        checkOutput("midrst_valid", 64'(uDoutValid), 64'd0);
        checkOutput("midrst_ovf", 64'(uOvf), 64'd0);
        applyStimulus(44'd10, 6'd2, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            applyStimulus(44'd5, 6'd7, 1'b0);
            if (k < 5) begin
                checkOutput($sformatf("postrst_k%0d_valid", k), 64'(uDoutValid), 64'd0);
                checkOutput($sformatf("postrst_k%0d_dout", k), 64'(uDout), 64'd0);
            end else if (k == 5) begin
                checkOutput("postrst_k5_valid", 64'(uDoutValid), 64'd1);
                checkOutput("postrst_k5_dout", 64'(uDout), 64'd20);
            end else begin
                checkOutput("postrst_k6_valid", 64'(uDoutValid), 64'd0);
                checkOutput("postrst_k6_dout", 64'(uDout), 64'd35);
            end
        end

        $display("[TB] signed scaled vectors");
        for (int c = 0; c < NV + SLAT; c++) begin
            if (c < NV) begin
                applySignedStimulus(vecs[c].a, vecs[c].b, 1'b1);
            end else begin
                applySignedStimulus(8'd0, 8'd0, 1'b0);
            end
            tick();
            j = c + 1 - SLAT;
            if (j < 0) begin
                checkOutput($sformatf("sgn_c%0d_idle_valid", c), 64'(satValid), 64'd0);
            end else if (j < NV) begin
                checkOutput($sformatf("sat_v%0d_valid", j), 64'(satValid), 64'd1);
                checkOutput($sformatf("sat_v%0d_dout", j), 64'(satDout), 64'(vecs[j].satDout));
                checkOutput($sformatf("sat_v%0d_ovf", j), 64'(satOvf), 64'(vecs[j].satOvf));
                checkOutput($sformatf("wrap_v%0d_valid", j), 64'(noValid), 64'd1);
                checkOutput($sformatf("wrap_v%0d_dout", j), 64'(noDout), 64'(vecs[j].noDout));
                checkOutput($sformatf("wrap_v%0d_ovf", j), 64'(noOvf), 64'(vecs[j].noOvf));
            end
        end
        tick();
        checkOutput("sgn_tail_valid", 64'(satValid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
